// File: rtl/frame_capture_if.sv
// Handshake, pixel-stream and frame-buffer write signals shared between
// frame_capture (master side) and its environment (slave side).
interface frame_capture_if #(
    parameter int ADDR_WIDTH = 15
);
    logic                  capture;
    logic                  busy;
    logic                  done;
    logic                  start;
    logic                  start_ack;
    logic                  valid;
    logic                  ready;
    logic [7:0]            pixel;
    logic                  mem_busy;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [7:0]            wr_data;

    modport master (
        input  capture, start_ack, valid, pixel, mem_busy,
        output busy, done, start, ready, wr_en, wr_addr, wr_data
    );

    modport slave (
        output capture, start_ack, valid, pixel, mem_busy,
        input  busy, done, start, ready, wr_en, wr_addr, wr_data
    );
endinterface

// File: rtl/frame_capture.sv
// Requests one frame from the pixel source, consumes the full stream and
// writes the centred IMG_WIDTH x IMG_HEIGHT window row-major to a frame buffer.
module frame_capture #(
    parameter int OUT_WIDTH  = 800,
    parameter int OUT_HEIGHT = 600,
    parameter int IMG_WIDTH  = 200,
    parameter int IMG_HEIGHT = 150,
    parameter int ADDR_WIDTH = 15
) (
    input  logic           clock,
    input  logic           reset,
    frame_capture_if.master bus
);

    localparam logic [9:0] X0       = 10'((OUT_WIDTH - IMG_WIDTH) / 2);
    localparam logic [9:0] Y0       = 10'((OUT_HEIGHT - IMG_HEIGHT) / 2);
    localparam logic [9:0] X_LAST   = 10'(((OUT_WIDTH - IMG_WIDTH) / 2) + IMG_WIDTH - 1);
    localparam logic [9:0] Y_LAST   = 10'(((OUT_HEIGHT - IMG_HEIGHT) / 2) + IMG_HEIGHT - 1);
    localparam logic [9:0] COL_LAST = 10'(OUT_WIDTH - 1);
    localparam logic [9:0] ROW_LAST = 10'(OUT_HEIGHT - 1);

    // Illegal parameter combinations are rejected at elaboration.
    if ((2 ** ADDR_WIDTH) < (IMG_WIDTH * IMG_HEIGHT)) begin : g_addr_check
        $error("frame_capture: ADDR_WIDTH too small for the capture window");
    end
    if ((OUT_WIDTH > 1023) || (OUT_HEIGHT > 1023)) begin : g_size_check
        $error("frame_capture: stream dimensions exceed 10-bit counters");
    end
    if ((IMG_WIDTH > OUT_WIDTH) || (IMG_HEIGHT > OUT_HEIGHT)) begin : g_win_check
        $error("frame_capture: window larger than stream frame");
    end

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        REQ  = 3'd1,
        REL  = 3'd2,
        RECV = 3'd3,
        DONE = 3'd4
    } state_t;

    state_t                state_r;
    logic                  busy_r;
    logic                  done_r;
    logic                  start_r;
    logic                  wr_en_r;
    logic [ADDR_WIDTH-1:0] wr_addr_r;
    logic [7:0]            wr_data_r;
    logic [9:0]            col_r;
    logic [9:0]            row_r;
    logic [ADDR_WIDTH-1:0] win_idx_r;

    logic                  ready_s;
    logic                  accept_s;
    logic                  in_window_s;
    logic                  last_beat_s;

    // Sink readiness: only while receiving, and only when the buffer can take a write.
    // A write registered from the previous accept still drains while mem_busy blocks
    // the next accept, so no data is lost.
    always_comb begin
        ready_s = 1'b0;
        if (state_r == RECV) begin
            ready_s = ~bus.mem_busy;
        end else begin
            ready_s = 1'b0;
        end
    end

    // Beat classification against the current stream position.
    always_comb begin
        accept_s    = bus.valid & ready_s;
        in_window_s = (col_r >= X0) && (col_r <= X_LAST) &&
                      (row_r >= Y0) && (row_r <= Y_LAST);
        last_beat_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
    end

    // Control FSM, stream position counters and registered write port.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r   <= IDLE;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            start_r   <= 1'b0;
            wr_en_r   <= 1'b0;
            wr_addr_r <= '0;
            wr_data_r <= 8'd0;
            col_r     <= 10'd0;
            row_r     <= 10'd0;
            win_idx_r <= '0;
        end else begin
            wr_en_r <= 1'b0;
            done_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (bus.capture) begin
                        state_r <= REQ;
                        busy_r  <= 1'b1;
                        start_r <= 1'b1;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                REQ: begin
                    if (bus.start_ack) begin
                        state_r <= REL;
                        start_r <= 1'b0;
                    end else begin
                        state_r <= REQ;
                    end
                end
                // The source begins its frame on the falling edge of start_ack.
                REL: begin
                    if (!bus.start_ack) begin
                        state_r   <= RECV;
                        col_r     <= 10'd0;
                        row_r     <= 10'd0;
                        win_idx_r <= '0;
                        wr_addr_r <= '0;
                    end else begin
                        state_r <= REL;
                    end
                end
                RECV: begin
                    if (accept_s) begin
                        if (in_window_s) begin
                            wr_en_r   <= 1'b1;
                            wr_data_r <= bus.pixel;
                            wr_addr_r <= win_idx_r;
                            win_idx_r <= win_idx_r + 1'b1;
                        end
                        if (col_r == COL_LAST) begin
                            col_r <= 10'd0;
                            row_r <= row_r + 10'd1;
                        end else begin
                            col_r <= col_r + 10'd1;
                        end
                        if (last_beat_s) begin
                            state_r <= DONE;
                            done_r  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                    start_r <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.start   = start_r;
    assign bus.ready   = ready_s;
    assign bus.wr_en   = wr_en_r;
    assign bus.wr_addr = wr_addr_r;
    assign bus.wr_data = wr_data_r;

endmodule

// File: tb/tb_frame_capture.sv
// Directed bench for frame_capture with an 8x6 stream and 4x2 window (X0=2, Y0=2);
// pixel value equals stream beat index.
module tb_frame_capture;

    localparam int OW = 8;
    localparam int OH = 6;
    localparam int IW = 4;
    localparam int IH = 2;
    localparam int NBEATS = OW * OH;
    localparam int NWR = IW * IH;

    logic clock = 1'b0;
    logic reset = 1'b1;
    logic ack_auto = 1'b0;
    logic ack_manual = 1'b0;
    logic ack_model_r;

    int n_checks = 0;
    int n_pass = 0;

    int wr_total = 0;
    int done_total = 0;
    logic [7:0] log_addr [64];
    logic [7:0] log_data [64];

    frame_capture_if #(.ADDR_WIDTH(3)) fc_if ();

    frame_capture #(
        .OUT_WIDTH (OW),
        .OUT_HEIGHT(OH),
        .IMG_WIDTH (IW),
        .IMG_HEIGHT(IH),
        .ADDR_WIDTH(3)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (fc_if.master)
    );

    always #5 clock = ~clock;

    // Model source: start_ack is a registered copy of start.
    always @(posedge clock or posedge reset) begin
        if (reset) ack_model_r <= 1'b0;
        else       ack_model_r <= fc_if.start;
    end
    assign fc_if.start_ack = ack_auto ? ack_model_r : ack_manual;

    // Write and done logger.
    always @(negedge clock) begin
        if (!reset && fc_if.wr_en) begin
            if (wr_total < 64) begin
                log_addr[wr_total] <= 8'(fc_if.wr_addr);
                log_data[wr_total] <= fc_if.wr_data;
            end
            wr_total <= wr_total + 1;
        end
        if (!reset && fc_if.done) done_total <= done_total + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    endtask

    typedef struct {
        logic cap, ack, mb, vld;
        logic e_busy, e_start, e_ready, e_done, e_wr;
    } vec_t;

    vec_t tbl [10];

    task automatic stream(input bit bp, input bit hold_cap, input int stop_at, output int beats);
        int cyc;
        bit acc;
        beats = 0;
        cyc = 0;
        while (beats < NBEATS && beats != stop_at && cyc < 2000) begin
            fc_if.capture  = hold_cap;
            fc_if.mem_busy = bp ? ($urandom_range(1, 0) == 1) : 1'b0;
            fc_if.valid    = bp ? ($urandom_range(9, 0) >= 3) : 1'b1;
            fc_if.pixel    = 8'(beats);
            #1;
            acc = fc_if.valid && fc_if.ready;
            @(negedge clock);
            if (acc) beats++;
            cyc++;
        end
    endtask

    task automatic run_frame(input bit bp, input bit hold_cap, input int stop_at, output int beats);
        @(negedge clock);
        fc_if.capture  = 1'b1;
        fc_if.valid    = 1'b0;
        fc_if.mem_busy = 1'b0;
        @(negedge clock);
        stream(bp, hold_cap, stop_at, beats);
    endtask

    // Called at the negedge right after the final beat was accepted.
    task automatic check_frame(input string tag, input int beats, input int base, input int dbase);
        int wx;
        chk({tag, "_beats"}, beats, NBEATS);
        fc_if.capture  = 1'b0;
        fc_if.valid    = 1'b0;
        fc_if.mem_busy = 1'b0;
        #1;
        chk({tag, "_done_pulse"}, fc_if.done, 1);
        chk({tag, "_busy_in_done"}, fc_if.busy, 1);
        @(negedge clock);
        #1;
        chk({tag, "_done_low"}, fc_if.done, 0);
        chk({tag, "_busy_low"}, fc_if.busy, 0);
        chk({tag, "_write_count"}, wr_total - base, NWR);
        chk({tag, "_done_count"}, done_total - dbase, 1);
        for (int k = 0; k < NWR; k++) begin
            wx = (2 + k / IW) * OW + 2 + (k % IW);
            if (base + k < 64) begin
                chk($sformatf("%s_addr%0d", tag, k), log_addr[base + k], k);
                chk($sformatf("%s_data%0d", tag, k), log_data[base + k], wx);
            end
        end
        @(negedge clock);
        #1;
        chk({tag, "_no_restart"}, fc_if.start, 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int beats;
        int base;
        int dbase;

        //              cap   ack   mb    vld   busy  start ready done  wr
        tbl[0] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[2] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[3] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        tbl[4] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[7] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        tbl[9] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        fc_if.capture  = 1'b0;
        fc_if.valid    = 1'b0;
        fc_if.mem_busy = 1'b0;
        fc_if.pixel    = 8'd0;

        // Reset state
        @(negedge clock);
        @(negedge clock);
        #1;
        chk("rst_busy", fc_if.busy, 0);
        chk("rst_start", fc_if.start, 0);
        chk("rst_ready", fc_if.ready, 0);
        chk("rst_done", fc_if.done, 0);
        chk("rst_wr_en", fc_if.wr_en, 0);
        chk("rst_wr_addr", fc_if.wr_addr, 0);
        chk("rst_wr_data", fc_if.wr_data, 0);
        @(negedge clock);
        reset = 1'b0;

        // Handshake vectors with a manually driven start_ack
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            fc_if.capture  = tbl[i].cap;
            ack_manual     = tbl[i].ack;
            fc_if.mem_busy = tbl[i].mb;
            fc_if.valid    = tbl[i].vld;
            fc_if.pixel    = 8'hA5;
            #1;
            chk($sformatf("hs%0d_busy", i), fc_if.busy, tbl[i].e_busy);
            chk($sformatf("hs%0d_start", i), fc_if.start, tbl[i].e_start);
            chk($sformatf("hs%0d_ready", i), fc_if.ready, tbl[i].e_ready);
            chk($sformatf("hs%0d_done", i), fc_if.done, tbl[i].e_done);
            chk($sformatf("hs%0d_wr_en", i), fc_if.wr_en, tbl[i].e_wr);
        end
        @(negedge clock);
        ack_auto = 1'b1;

        // Frame continuing from the handshake, no backpressure
        base = wr_total;
        dbase = done_total;
        stream(1'b0, 1'b0, -1, beats);
        check_frame("f_plain", beats, base, dbase);

        // Backpressure: random mem_busy and valid gaps
        base = wr_total;
        dbase = done_total;
        run_frame(1'b1, 1'b0, -1, beats);
        check_frame("f_bp", beats, base, dbase);

        // Capture held high throughout the frame
        base = wr_total;
        dbase = done_total;
        run_frame(1'b0, 1'b1, -1, beats);
        check_frame("f_hold", beats, base, dbase);

        // Asynchronous reset mid-frame, then a fresh capture
        run_frame(1'b0, 1'b0, 20, beats);
        chk("partial_beats", beats, 20);
        #3;
        reset = 1'b1;
        #1;
        chk("amid_busy", fc_if.busy, 0);
        chk("amid_start", fc_if.start, 0);
        chk("amid_ready", fc_if.ready, 0);
        chk("amid_done", fc_if.done, 0);
        chk("amid_wr_en", fc_if.wr_en, 0);
        chk("amid_wr_addr", fc_if.wr_addr, 0);
        chk("amid_wr_data", fc_if.wr_data, 0);
        @(negedge clock);
        reset = 1'b0;
        fc_if.valid = 1'b0;
        base = wr_total;
        dbase = done_total;
        run_frame(1'b1, 1'b0, -1, beats);
        check_frame("f_after_rst", beats, base, dbase);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
